pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Instruction-fetch stage sitting directly upstream of pc_rom: owns the program
//  counter, drives pc_rom.A, captures pc_rom.RD into an IF/ID register and offers
//  it to decode over a valid/ready handshake. Handles stall backpressure, branch/
//  jump redirect with one-bubble flush, and misaligned-target reporting.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset (byte address, word aligned)
//  NOP_INSTR  32'h0000_0013  value held in id_instr while reset/flushed (addi x0,x0,0)
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   synchronous reset, active-high
//  fetch_en         in   1   1 = fetch allowed; 0 = no new fetch, PC holds
//  rom_addr         out  32  byte address to pc_rom.A (= current PC, combinational)
//  rom_data         in   32  instruction word from pc_rom.RD (combinational, same cycle)
//  redirect_valid   in   1   branch/jump taken this cycle
//  redirect_target  in   32  new PC (byte address)
//  id_valid         out  1   IF/ID register holds a valid instruction
//  id_ready         in   1   decode accepts IF/ID contents this cycle
//  id_pc            out  32  PC of instruction in IF/ID
//  id_instr         out  32  instruction word in IF/ID
//  id_pc_plus4      out  32  id_pc + 4 (mod 2^32), registered
//  misalign_err     out  1   one-cycle pulse: redirect_target[1:0] != 0
//  fetch_count      out  32  number of instructions loaded into IF/ID since reset
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc=RESET_PC, id_valid=0, id_pc=0, id_instr=NOP_INSTR,
//    id_pc_plus4=0, misalign_err=0, fetch_count=0. Reset overrides all inputs, incl.
//    mid-stall or in the same cycle as redirect.
//  - rom_addr = pc at all times; pc[1:0] is always 2'b00.
//  - accept = fetch_en & (!id_valid | id_ready)   // IF/ID free or being drained
//  - Priority per edge: rst > redirect_valid > accept > hold.
//  - Redirect: pc <= {redirect_target[31:2],2'b00}; id_valid <= 0; id_instr <= NOP_INSTR;
//    fetch_count unchanged. misalign_err <= |redirect_target[1:0] (else 0). Instruction
//    in IF/ID at the redirect edge counts as consumed only if id_ready=1 (decode's
//    concern); it is dropped either way. Result: exactly one bubble, target fetched on
//    the following edge.
//  - Accept (no redirect): id_pc <= pc; id_instr <= rom_data; id_pc_plus4 <= pc+4;
//    id_valid <= 1; pc <= pc+4 (wraps 32'hFFFF_FFFC -> 0); fetch_count += 1 (wraps).
//  - Hold (no redirect, no accept): pc and IF/ID unchanged; if fetch_en=0 and
//    id_ready=1 & id_valid=1, id_valid <= 0 (drained, no refill).
//  - misalign_err is 0 on every edge without a misaligned redirect.
//  - Latency: PC->id_valid one cycle; throughput one instruction/cycle with id_ready=1.
// TESTING  (bench wires rom_addr/rom_data to pc_rom, whose word i holds value i)
//  1 rst 2 cycles, then fetch_en=1,id_ready=1 -> 1st edge: id_valid=1,id_pc=0,
//    id_instr=0; then id_pc=4/instr=1, 8/2,...; fetch_count=n after n edges.
//  2 Stall: id_ready=0 while id_pc=0x10 for 3 cycles -> id_pc=0x10, id_instr=4,
//    pc=0x14 held; release -> next id_pc=0x14, id_instr=5, no skip/duplicate.
//  3 Redirect target 0x40 with id_ready=1 -> next edge id_valid=0, id_instr=NOP;
//    edge after: id_pc=0x40, id_instr=0x10, id_pc_plus4=0x44.
//  4 Redirect target 0x42 -> misalign_err=1 for exactly one cycle, then id_pc=0x40.
//  5 Redirect and id_ready=0 together -> redirect wins, bubble, then target fetched.
//  6 RESET_PC=32'hFFFF_FFFC: first id_pc=FFFF_FFFC, id_pc_plus4=0, next id_pc=0;
//    assert rst mid-run with stall -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/pc_fetch_if.sv
// rtl/pc_fetch_if.sv - IF/ID handshake bundle between fetch and decode
//
// Purpose: carries the IF/ID register contents and the valid/ready handshake
//          from the fetch stage to decode.
// Signals:
//   id_valid     fetch -> decode  IF/ID register holds a valid instruction
//   id_ready     decode -> fetch  decode accepts IF/ID contents this cycle
//   id_pc        fetch -> decode  PC of the instruction in IF/ID
//   id_instr     fetch -> decode  instruction word in IF/ID
//   id_pc_plus4  fetch -> decode  id_pc + 4 (mod 2^32)
// Modports: master = fetch side, slave = decode side.
interface pc_fetch_if;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;

  modport master (
    output id_valid,
    output id_pc,
    output id_instr,
    output id_pc_plus4,
    input  id_ready
  );

  modport slave (
    input  id_valid,
    input  id_pc,
    input  id_instr,
    input  id_pc_plus4,
    output id_ready
  );
endinterface

// File: rtl/pc_fetch.sv
// rtl/pc_fetch.sv - instruction fetch stage: PC, ROM address, IF/ID register
//
// Purpose: owns the program counter, addresses the instruction ROM
//          combinationally, captures the returned word into the IF/ID register
//          and offers it to decode. Handles decode backpressure, branch/jump
//          redirect with a one-bubble flush, and misaligned-target reporting.
// Parameters:
//   RESET_PC   PC loaded on reset (byte address, word aligned)
//   NOP_INSTR  value held in id_instr while reset or flushed
// Ports:
//   clk              in   clock, all state on rising edge
//   rst              in   synchronous reset, active-high
//   fetch_en         in   1 = fetch allowed; 0 = no new fetch, PC holds
//   rom_addr         out  byte address to the ROM (= current PC)
//   rom_data         in   instruction word from the ROM, same cycle
//   redirect_valid   in   branch/jump taken this cycle
//   redirect_target  in   new PC (byte address)
//   dec              if   IF/ID handshake to decode (master side)
//   misalign_err     out  one-cycle pulse on a redirect with target[1:0] != 0
//   fetch_count      out  instructions loaded into IF/ID since reset
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [31:0]       rom_addr,
  input  logic [31:0]       rom_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  pc_fetch_if.master        dec,
  output logic              misalign_err,
  output logic [31:0]       fetch_count
);

  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic        accept;

  // A new word may enter IF/ID when it is empty or being drained this cycle.
  assign accept   = fetch_en & (~id_valid | dec.id_ready);
  assign rom_addr = pc;

  assign dec.id_valid    = id_valid;
  assign dec.id_pc       = id_pc;
  assign dec.id_instr    = id_instr;
  assign dec.id_pc_plus4 = id_pc_plus4;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= {RESET_PC[31:2], 2'b00};
      id_valid     <= 1'b0;
      id_pc        <= 32'h0;
      id_instr     <= NOP_INSTR;
      id_pc_plus4  <= 32'h0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'h0;
    end else begin
      misalign_err <= 1'b0;
      if (redirect_valid) begin
        // Whatever sits in IF/ID is wrong-path: drop it and leave one bubble.
        // The low target bits are discarded so the PC stays word aligned.
        pc           <= {redirect_target[31:2], 2'b00};
        id_valid     <= 1'b0;
        id_instr     <= NOP_INSTR;
        misalign_err <= |redirect_target[1:0];
      end else if (accept) begin
        id_pc       <= pc;
        id_instr    <= rom_data;
        id_pc_plus4 <= pc + 32'd4;
        id_valid    <= 1'b1;
        pc          <= pc + 32'd4;
        fetch_count <= fetch_count + 32'd1;
      end else if (!fetch_en && dec.id_ready && id_valid) begin
        // Decode took the last word and fetch is paused: empty, no refill.
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// tb/tb_pc_fetch.sv - directed self-checking bench for pc_fetch
module tb_pc_fetch;
  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] rom_addr, rom_data;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic        rst2, fetch_en2;
  logic [31:0] rom_addr2, rom_data2;
  logic        misalign_err2;
  logic [31:0] fetch_count2;

  int tests = 0;
  int fails = 0;

  pc_fetch_if dif ();
  pc_fetch_if dif2 ();

  // ROM model: word i holds value i.
  assign rom_data  = {2'b00, rom_addr[31:2]};
  assign rom_data2 = {2'b00, rom_addr2[31:2]};

  pc_fetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .dec(dif), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .fetch_en(fetch_en2),
    .rom_addr(rom_addr2), .rom_data(rom_data2),
    .redirect_valid(1'b0), .redirect_target(32'h0),
    .dec(dif2), .misalign_err(misalign_err2), .fetch_count(fetch_count2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    dif.id_ready = 1'b0;
    tick(); tick();
    tests++;
    if ({dif.id_valid, dif.id_pc, dif.id_instr, dif.id_pc_plus4} !== {1'b0, 32'h0, 32'h13, 32'h0}) begin
      fails++;
      $display("FAIL reset_ifid got v=%0b pc=%h instr=%h p4=%h want v=0 pc=0 instr=13 p4=0",
               dif.id_valid, dif.id_pc, dif.id_instr, dif.id_pc_plus4);
    end
    tests++;
    if ({misalign_err, fetch_count, rom_addr} !== {1'b0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_misc got err=%0b cnt=%0d addr=%h want 0/0/0", misalign_err, fetch_count, rom_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [31:0] exp_in [5] = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
    rst = 1'b0; fetch_en = 1'b1; dif.id_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      tests++;
      if ({dif.id_valid, dif.id_pc, dif.id_instr, dif.id_pc_plus4, fetch_count} !==
          {1'b1, exp_pc[n], exp_in[n], exp_pc[n] + 32'd4, 32'(n + 1)}) begin
        fails++;
        $display("FAIL stream_%0d got v=%0b pc=%h instr=%h p4=%h cnt=%0d want v=1 pc=%h instr=%h p4=%h cnt=%0d",
                 n, dif.id_valid, dif.id_pc, dif.id_instr, dif.id_pc_plus4, fetch_count,
                 exp_pc[n], exp_in[n], exp_pc[n] + 32'd4, n + 1);
      end
    end
  endtask

  task automatic test_stall();
    dif.id_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      tests++;
      if ({dif.id_valid, dif.id_pc, dif.id_instr, rom_addr, fetch_count} !==
          {1'b1, 32'h10, 32'h4, 32'h14, 32'd5}) begin
        fails++;
        $display("FAIL stall_%0d got v=%0b pc=%h instr=%h addr=%h cnt=%0d want v=1 pc=10 instr=4 addr=14 cnt=5",
                 n, dif.id_valid, dif.id_pc, dif.id_instr, rom_addr, fetch_count);
      end
    end
    dif.id_ready = 1'b1;
    tick();
    tests++;
    if ({dif.id_valid, dif.id_pc, dif.id_instr, fetch_count} !== {1'b1, 32'h14, 32'h5, 32'd6}) begin
      fails++;
      $display("FAIL stall_release got v=%0b pc=%h instr=%h cnt=%0d want v=1 pc=14 instr=5 cnt=6",
               dif.id_valid, dif.id_pc, dif.id_instr, fetch_count);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    tests++;
    if ({dif.id_valid, dif.id_instr, rom_addr, fetch_count, misalign_err} !==
        {1'b0, 32'h13, 32'h40, 32'd6, 1'b0}) begin
      fails++;
      $display("FAIL redirect_bubble got v=%0b instr=%h addr=%h cnt=%0d err=%0b want v=0 instr=13 addr=40 cnt=6 err=0",
               dif.id_valid, dif.id_instr, rom_addr, fetch_count, misalign_err);
    end
    redirect_valid = 1'b0;
    tick();
    tests++;
    if ({dif.id_valid, dif.id_pc, dif.id_instr, dif.id_pc_plus4, fetch_count} !==
        {1'b1, 32'h40, 32'h10, 32'h44, 32'd7}) begin
      fails++;
      $display("FAIL redirect_target got v=%0b pc=%h instr=%h p4=%h cnt=%0d want v=1 pc=40 instr=10 p4=44 cnt=7",
               dif.id_valid, dif.id_pc, dif.id_instr, dif.id_pc_plus4, fetch_count);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick();
    tests++;
    if ({misalign_err, dif.id_valid, rom_addr} !== {1'b1, 1'b0, 32'h40}) begin
      fails++;
      $display("FAIL misalign_pulse got err=%0b v=%0b addr=%h want err=1 v=0 addr=40",
               misalign_err, dif.id_valid, rom_addr);
    end
    redirect_valid = 1'b0;
    tick();
    tests++;
    if ({misalign_err, dif.id_valid, dif.id_pc, dif.id_instr, fetch_count} !==
        {1'b0, 1'b1, 32'h40, 32'h10, 32'd8}) begin
      fails++;
      $display("FAIL misalign_after got err=%0b v=%0b pc=%h instr=%h cnt=%0d want err=0 v=1 pc=40 instr=10 cnt=8",
               misalign_err, dif.id_valid, dif.id_pc, dif.id_instr, fetch_count);
    end
  endtask

  task automatic test_redirect_stall();
    redirect_valid = 1'b1; redirect_target = 32'h80; dif.id_ready = 1'b0;
    tick();
    tests++;
    if ({dif.id_valid, dif.id_instr, rom_addr, fetch_count} !== {1'b0, 32'h13, 32'h80, 32'd8}) begin
      fails++;
      $display("FAIL redir_stall_bubble got v=%0b instr=%h addr=%h cnt=%0d want v=0 instr=13 addr=80 cnt=8",
               dif.id_valid, dif.id_instr, rom_addr, fetch_count);
    end
    redirect_valid = 1'b0; dif.id_ready = 1'b1;
    tick();
    tests++;
    if ({dif.id_valid, dif.id_pc, dif.id_instr, fetch_count} !== {1'b1, 32'h80, 32'h20, 32'd9}) begin
      fails++;
      $display("FAIL redir_stall_target got v=%0b pc=%h instr=%h cnt=%0d want v=1 pc=80 instr=20 cnt=9",
               dif.id_valid, dif.id_pc, dif.id_instr, fetch_count);
    end
  endtask

  task automatic test_drain_and_reset();
    fetch_en = 1'b0; dif.id_ready = 1'b1;
    tick();
    tests++;
    if ({dif.id_valid, rom_addr, fetch_count} !== {1'b0, 32'h84, 32'd9}) begin
      fails++;
      $display("FAIL drain got v=%0b addr=%h cnt=%0d want v=0 addr=84 cnt=9", dif.id_valid, rom_addr, fetch_count);
    end
    fetch_en = 1'b1;
    tick();
    dif.id_ready = 1'b0;
    tick();
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h103;
    tick();
    tests++;
    if ({dif.id_valid, dif.id_pc, dif.id_instr, dif.id_pc_plus4, misalign_err, fetch_count, rom_addr} !==
        {1'b0, 32'h0, 32'h13, 32'h0, 1'b0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_mid_stall got v=%0b pc=%h instr=%h p4=%h err=%0b cnt=%0d addr=%h want all reset values",
               dif.id_valid, dif.id_pc, dif.id_instr, dif.id_pc_plus4, misalign_err, fetch_count, rom_addr);
    end
    rst = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_wrap();
    tick();
    tests++;
    if (rom_addr2 !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL wrap_reset_pc got %h want FFFFFFFC", rom_addr2);
    end
    rst2 = 1'b0; fetch_en2 = 1'b1; dif2.id_ready = 1'b1;
    tick();
    tests++;
    if ({dif2.id_valid, dif2.id_pc, dif2.id_instr, dif2.id_pc_plus4, rom_addr2} !==
        {1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL wrap_first got v=%0b pc=%h instr=%h p4=%h addr=%h want v=1 pc=FFFFFFFC instr=3FFFFFFF p4=0 addr=0",
               dif2.id_valid, dif2.id_pc, dif2.id_instr, dif2.id_pc_plus4, rom_addr2);
    end
    tick();
    tests++;
    if ({dif2.id_pc, dif2.id_instr, dif2.id_pc_plus4, fetch_count2} !== {32'h0, 32'h0, 32'h4, 32'd2}) begin
      fails++;
      $display("FAIL wrap_second got pc=%h instr=%h p4=%h cnt=%0d want pc=0 instr=0 p4=4 cnt=2",
               dif2.id_pc, dif2.id_instr, dif2.id_pc_plus4, fetch_count2);
    end
    dif2.id_ready = 1'b0;
    tick();
    rst2 = 1'b1;
    tick();
    tests++;
    if ({dif2.id_valid, dif2.id_pc, dif2.id_instr, dif2.id_pc_plus4, fetch_count2, rom_addr2} !==
        {1'b0, 32'h0, 32'h13, 32'h0, 32'h0, 32'hFFFF_FFFC}) begin
      fails++;
      $display("FAIL wrap_reset_stall got v=%0b pc=%h instr=%h p4=%h cnt=%0d addr=%h want v=0 pc=0 instr=13 p4=0 cnt=0 addr=FFFFFFFC",
               dif2.id_valid, dif2.id_pc, dif2.id_instr, dif2.id_pc_plus4, fetch_count2, rom_addr2);
    end
  endtask

  initial begin
    rst2 = 1'b1; fetch_en2 = 1'b0; dif2.id_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misalign();
    test_redirect_stall();
    test_drain_and_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
